// File: rtl/rr_dispatch_1to2_if.sv
// Handshake bundle for the 1-to-2 round-robin dispatcher: upstream valid/ready,
// per-channel consumer ready, decoder select/enable, payload and dispatch counters.
interface rr_dispatch_1to2_if;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ready;
    logic [1:0] rdy1_rdy0;
    logic       x0;
    logic       e;
    logic [7:0] dout;
    logic [7:0] cnt0;
    logic [7:0] cnt1;

    modport master (
        output in_valid, in_data, rdy1_rdy0,
        input  in_ready, x0, e, dout, cnt0, cnt1
    );

    modport slave (
        input  in_valid, in_data, rdy1_rdy0,
        output in_ready, x0, e, dout, cnt0, cnt1
    );
endinterface

// File: rtl/rr_dispatch_1to2.sv
// One-entry buffer that dispatches each item to one of two consumers in
// round-robin order, driving a 1-to-2 enabled decoder (x0 = select, e = enable).
module rr_dispatch_1to2 (
    input  logic              clock,
    input  logic              reset,
    rr_dispatch_1to2_if.slave bus
);

    typedef enum logic [0:0] {
        EMPTY = 1'b0,
        HOLD  = 1'b1
    } state_t;

    state_t     state_r;
    state_t     state_next_s;
    logic [7:0] data_r;
    logic [7:0] data_next_s;
    logic       ptr_r;
    logic       ptr_next_s;
    logic [7:0] cnt0_r;
    logic [7:0] cnt1_r;

    logic       dispatch_s;
    logic       chosen_s;
    logic       in_ready_s;
    logic       x0_s;
    logic       accept_s;

    // State register: holding entry, round-robin pointer and dispatch counters
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_r <= EMPTY;
            data_r  <= 8'h00;
            ptr_r   <= 1'b0;
            cnt0_r  <= 8'h00;
            cnt1_r  <= 8'h00;
        end else begin
            state_r <= state_next_s;
            data_r  <= data_next_s;
            ptr_r   <= ptr_next_s;
            if (dispatch_s && (chosen_s == 1'b0)) begin
                cnt0_r <= cnt0_r + 8'd1;
            end else begin
                cnt0_r <= cnt0_r;
            end
            if (dispatch_s && (chosen_s == 1'b1)) begin
                cnt1_r <= cnt1_r + 8'd1;
            end else begin
                cnt1_r <= cnt1_r;
            end
        end
    end

    // Output decode: dispatch strobe, channel choice and upstream ready
    always_comb begin
        dispatch_s = 1'b0;
        chosen_s   = 1'b0;
        in_ready_s = 1'b0;
        x0_s       = 1'b0;
        if (state_r == HOLD) begin
            dispatch_s = (bus.rdy1_rdy0 != 2'b00);
        end else begin
            dispatch_s = 1'b0;
        end
        // Prefer the pointed channel; fall back to the other one when it is busy
        if (bus.rdy1_rdy0[ptr_r]) begin
            chosen_s = ptr_r;
        end else begin
            chosen_s = ~ptr_r;
        end
        if (dispatch_s) begin
            x0_s = chosen_s;
        end else begin
            x0_s = 1'b0;
        end
        in_ready_s = (state_r == EMPTY) || dispatch_s;
    end

    assign accept_s = bus.in_valid && in_ready_s;

    // Next-state logic for the holding entry and the round-robin pointer
    always_comb begin
        state_next_s = state_r;
        data_next_s  = data_r;
        ptr_next_s   = ptr_r;
        case (state_r)
            EMPTY: begin
                if (bus.in_valid) begin
                    state_next_s = HOLD;
                end else begin
                    state_next_s = EMPTY;
                end
            end
            HOLD: begin
                if (dispatch_s && !bus.in_valid) begin
                    state_next_s = EMPTY;
                end else begin
                    state_next_s = HOLD;
                end
            end
            default: begin
                state_next_s = EMPTY;
            end
        endcase
        if (accept_s) begin
            data_next_s = bus.in_data;
        end else begin
            data_next_s = data_r;
        end
        if (dispatch_s) begin
            ptr_next_s = ~chosen_s;
        end else begin
            ptr_next_s = ptr_r;
        end
    end

    assign bus.in_ready = in_ready_s;
    assign bus.e        = dispatch_s;
    assign bus.x0       = x0_s;
    assign bus.dout     = data_r;
    assign bus.cnt0     = cnt0_r;
    assign bus.cnt1     = cnt1_r;

endmodule

// File: tb/tb_rr_dispatch_1to2.sv
// Bench for rr_dispatch_1to2: vector table for the stream/stall/skip paths,
// hand sequences for reset, wrap and reset-while-holding, plus a payload scoreboard.
module tb_rr_dispatch_1to2;

    logic clock;
    logic reset;

    rr_dispatch_1to2_if bus ();

    rr_dispatch_1to2 dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int total = 0;
    int bad   = 0;
    logic [7:0] sb[$];

    typedef struct {
        logic       v;
        logic [7:0] d;
        logic [1:0] rdy;
        logic       exp_ready;
        logic       exp_e;
        logic       exp_x0;
        logic [7:0] exp_dout;
        logic [7:0] exp_cnt0;
        logic [7:0] exp_cnt1;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic apply(input logic v, input logic [7:0] d, input logic [1:0] r);
        @(negedge clock);
        bus.in_valid  = v;
        bus.in_data   = d;
        bus.rdy1_rdy0 = r;
        #2;
    endtask

    task automatic do_reset();
        reset         = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_data   = 8'h00;
        bus.rdy1_rdy0 = 2'b00;
        sb.delete();
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
    endtask

    // Scoreboard: pop the oldest accepted item on each dispatch, then record a new accept
    always @(negedge clock) begin
        #3;
        if (reset) begin
            sb.delete();
        end else begin
            if (bus.e === 1'b1) begin
                if (sb.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL sb_spurious: dispatched %0h with nothing pending", bus.dout);
                end else begin
                    chk("sb_dout", {24'd0, bus.dout}, {24'd0, sb.pop_front()});
                end
            end
            if (bus.in_valid && bus.in_ready) begin
                sb.push_back(bus.in_data);
            end
        end
    end

    function automatic vec_t mk(input logic v, input logic [7:0] d, input logic [1:0] r,
                                input logic er, input logic ee, input logic ex,
                                input logic [7:0] edo, input logic [7:0] c0, input logic [7:0] c1);
        vec_t t;
        t.v = v; t.d = d; t.rdy = r;
        t.exp_ready = er; t.exp_e = ee; t.exp_x0 = ex;
        t.exp_dout = edo; t.exp_cnt0 = c0; t.exp_cnt1 = c1;
        return t;
    endfunction

    initial begin
        int disp;
        reset         = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_data   = 8'h00;
        bus.rdy1_rdy0 = 2'b11;
        #2;
        chk("rst_e",     {31'd0, bus.e},        32'd0);
        chk("rst_x0",    {31'd0, bus.x0},       32'd0);
        chk("rst_ready", {31'd0, bus.in_ready}, 32'd1);
        chk("rst_dout",  {24'd0, bus.dout},     32'd0);
        do_reset();

        // Idle after reset
        for (int i = 0; i < 5; i++) begin
            apply(1'b0, 8'h00, 2'b11);
            chk("idle_e",     {31'd0, bus.e},        32'd0);
            chk("idle_ready", {31'd0, bus.in_ready}, 32'd1);
            chk("idle_cnt0",  {24'd0, bus.cnt0},     32'd0);
            chk("idle_cnt1",  {24'd0, bus.cnt1},     32'd0);
        end

        //          v     d      rdy    rdy  e    x0   dout   c0     c1
        vecs.push_back(mk(1'b1, 8'hA0, 2'b11, 1'b1, 1'b0, 1'b0, 8'h00, 8'd0, 8'd0));
        vecs.push_back(mk(1'b1, 8'hA1, 2'b11, 1'b1, 1'b1, 1'b0, 8'hA0, 8'd0, 8'd0));
        vecs.push_back(mk(1'b1, 8'hA2, 2'b11, 1'b1, 1'b1, 1'b1, 8'hA1, 8'd1, 8'd0));
        vecs.push_back(mk(1'b1, 8'hA3, 2'b11, 1'b1, 1'b1, 1'b0, 8'hA2, 8'd1, 8'd1));
        vecs.push_back(mk(1'b0, 8'h00, 2'b11, 1'b1, 1'b1, 1'b1, 8'hA3, 8'd2, 8'd1));
        vecs.push_back(mk(1'b0, 8'h00, 2'b11, 1'b1, 1'b0, 1'b0, 8'hA3, 8'd2, 8'd2));
        vecs.push_back(mk(1'b1, 8'h5C, 2'b00, 1'b1, 1'b0, 1'b0, 8'hA3, 8'd2, 8'd2));
        vecs.push_back(mk(1'b1, 8'hD1, 2'b00, 1'b0, 1'b0, 1'b0, 8'h5C, 8'd2, 8'd2));
        vecs.push_back(mk(1'b1, 8'hD1, 2'b00, 1'b0, 1'b0, 1'b0, 8'h5C, 8'd2, 8'd2));
        vecs.push_back(mk(1'b1, 8'hD1, 2'b00, 1'b0, 1'b0, 1'b0, 8'h5C, 8'd2, 8'd2));
        vecs.push_back(mk(1'b1, 8'hD1, 2'b01, 1'b1, 1'b1, 1'b0, 8'h5C, 8'd2, 8'd2));
        vecs.push_back(mk(1'b0, 8'h00, 2'b11, 1'b1, 1'b1, 1'b1, 8'hD1, 8'd3, 8'd2));
        vecs.push_back(mk(1'b1, 8'h11, 2'b10, 1'b1, 1'b0, 1'b0, 8'hD1, 8'd3, 8'd3));
        vecs.push_back(mk(1'b0, 8'h00, 2'b10, 1'b1, 1'b1, 1'b1, 8'h11, 8'd3, 8'd3));
        vecs.push_back(mk(1'b1, 8'h22, 2'b00, 1'b1, 1'b0, 1'b0, 8'h11, 8'd3, 8'd4));
        vecs.push_back(mk(1'b0, 8'h00, 2'b11, 1'b1, 1'b1, 1'b0, 8'h22, 8'd3, 8'd4));
        vecs.push_back(mk(1'b0, 8'h00, 2'b11, 1'b1, 1'b0, 1'b0, 8'h22, 8'd4, 8'd4));
        vecs.push_back(mk(1'b1, 8'h33, 2'b00, 1'b1, 1'b0, 1'b0, 8'h22, 8'd4, 8'd4));
        vecs.push_back(mk(1'b0, 8'h00, 2'b01, 1'b1, 1'b1, 1'b0, 8'h33, 8'd4, 8'd4));
        vecs.push_back(mk(1'b1, 8'h44, 2'b11, 1'b1, 1'b0, 1'b0, 8'h33, 8'd5, 8'd4));
        vecs.push_back(mk(1'b0, 8'h00, 2'b11, 1'b1, 1'b1, 1'b1, 8'h44, 8'd5, 8'd4));
        vecs.push_back(mk(1'b0, 8'h00, 2'b00, 1'b1, 1'b0, 1'b0, 8'h44, 8'd5, 8'd5));

        foreach (vecs[k]) begin
            apply(vecs[k].v, vecs[k].d, vecs[k].rdy);
            chk($sformatf("v%0d_ready", k), {31'd0, bus.in_ready}, {31'd0, vecs[k].exp_ready});
            chk($sformatf("v%0d_e", k),     {31'd0, bus.e},        {31'd0, vecs[k].exp_e});
            chk($sformatf("v%0d_x0", k),    {31'd0, bus.x0},       {31'd0, vecs[k].exp_x0});
            chk($sformatf("v%0d_dout", k),  {24'd0, bus.dout},     {24'd0, vecs[k].exp_dout});
            chk($sformatf("v%0d_cnt0", k),  {24'd0, bus.cnt0},     {24'd0, vecs[k].exp_cnt0});
            chk($sformatf("v%0d_cnt1", k),  {24'd0, bus.cnt1},     {24'd0, vecs[k].exp_cnt1});
        end
        @(negedge clock);
        #4;
        chk("table_sb_empty", sb.size(), 32'd0);

        // Counter wrap: 256 items to channel 0 only
        do_reset();
        disp = 0;
        for (int i = 0; i < 256; i++) begin
            apply(1'b1, i[7:0], 2'b01);
            chk("wrap_ready", {31'd0, bus.in_ready}, 32'd1);
            if (bus.e === 1'b1) begin
                disp++;
                chk("wrap_x0", {31'd0, bus.x0}, 32'd0);
            end
            if (i == 255) begin
                chk("wrap_cnt0_mid", {24'd0, bus.cnt0}, 32'd254);
            end
        end
        for (int i = 0; i < 10; i++) begin
            apply(1'b0, 8'h00, 2'b01);
            if (bus.e === 1'b1) disp++;
        end
        chk("wrap_disp",  disp, 32'd256);
        chk("wrap_cnt0",  {24'd0, bus.cnt0}, 32'd0);
        chk("wrap_cnt1",  {24'd0, bus.cnt1}, 32'd0);
        #2;
        chk("wrap_sb_empty", sb.size(), 32'd0);

        // Reset while holding 8'h77: the item must be discarded
        do_reset();
        apply(1'b1, 8'h77, 2'b00);
        apply(1'b0, 8'h00, 2'b00);
        chk("hold_ready", {31'd0, bus.in_ready}, 32'd0);
        chk("hold_dout",  {24'd0, bus.dout},     32'd119);
        #2;
        reset = 1'b1;
        #1;
        chk("arst_e",     {31'd0, bus.e},        32'd0);
        chk("arst_x0",    {31'd0, bus.x0},       32'd0);
        chk("arst_ready", {31'd0, bus.in_ready}, 32'd1);
        chk("arst_dout",  {24'd0, bus.dout},     32'd0);
        sb.delete();
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            apply(1'b0, 8'h00, 2'b11);
            chk("post_rst_e", {31'd0, bus.e}, 32'd0);
        end
        apply(1'b1, 8'h88, 2'b11);
        apply(1'b0, 8'h00, 2'b11);
        chk("post_rst_disp_e",    {31'd0, bus.e},    32'd1);
        chk("post_rst_disp_x0",   {31'd0, bus.x0},   32'd0);
        chk("post_rst_disp_dout", {24'd0, bus.dout}, 32'd136);
        apply(1'b0, 8'h00, 2'b11);
        chk("post_rst_cnt0", {24'd0, bus.cnt0}, 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
